// File: rtl/decode_64b67b_sync_if.sv
// Stream bundle for the 64B/67B block-sync decoder.
// Unaligned words go in, aligned payloads and headers come out.
interface decode_64b67b_sync_if;
   logic [66:0] DATA_IN;
   logic        DATA_IN_VALID;
   logic [63:0] DATA_OUT;
   logic [1:0]  HEADER_OUT;
   logic        DATA_OUT_VALID;
   logic        HEADER_ERR;

   modport master (
      output DATA_IN, DATA_IN_VALID,
      input  DATA_OUT, HEADER_OUT, DATA_OUT_VALID, HEADER_ERR
   );

   modport slave (
      input  DATA_IN, DATA_IN_VALID,
      output DATA_OUT, HEADER_OUT, DATA_OUT_VALID, HEADER_ERR
   );
endinterface

// File: rtl/decode_64b67b_sync.sv
// Interlaken 64B/67B block-sync decoder for one lane.
// Hunts all 67 bit offsets, locks, and emits aligned payloads.
module decode_64b67b_sync #(
   parameter int LOCK_CNT   = 64,
   parameter int ERR_LIMIT  = 16,
   parameter int ERR_WINDOW = 64,
   parameter int SLIP_WAIT  = 2,
   parameter int INVERT_EN  = 1
) (
   input  logic                       USER_CLK,
   input  logic                       SYSTEM_RESET,
   input  logic                       PASSTHROUGH,
   decode_64b67b_sync_if.slave        bus,
   output logic                       LOCKED,
   output logic [6:0]                 CANDIDATE,
   output logic [15:0]                LOCK_LOSS_CNT
);

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_WAIT,
      ST_LOCKED
   } state_t;

   state_t      state, state_nxt;
   logic [66:0] prev;
   logic [133:0] window;
   logic        chk_v;
   logic [66:0] aligned;
   logic        good;
   logic [6:0]  cand, cand_nxt;
   logic [9:0]  good_cnt, good_nxt;
   logic [3:0]  wait_cnt, wait_nxt;
   logic [9:0]  win_cnt, win_nxt;
   logic [9:0]  err_cnt, err_nxt;
   logic [15:0] loss_cnt, loss_nxt;

   assign aligned       = 67'(window >> cand);
   assign good          = aligned[65] ^ aligned[64];
   assign LOCKED        = (state == ST_LOCKED);
   assign CANDIDATE     = cand;
   assign LOCK_LOSS_CNT = loss_cnt;

   // Two-word search window; newest word sits in the upper half
   always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         prev   <= '0;
         window <= '0;
         chk_v  <= 1'b0;
      end else begin
         chk_v <= bus.DATA_IN_VALID;
         if (bus.DATA_IN_VALID) begin
            prev   <= bus.DATA_IN;
            window <= {bus.DATA_IN, prev};
         end
      end
   end

   // Sync FSM state and counters
   always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         state    <= ST_HUNT;
         cand     <= '0;
         good_cnt <= '0;
         wait_cnt <= '0;
         win_cnt  <= '0;
         err_cnt  <= '0;
         loss_cnt <= '0;
      end else begin
         state    <= state_nxt;
         cand     <= cand_nxt;
         good_cnt <= good_nxt;
         wait_cnt <= wait_nxt;
         win_cnt  <= win_nxt;
         err_cnt  <= err_nxt;
         loss_cnt <= loss_nxt;
      end
   end

   // Hunt / slip hold-off / locked error-window decisions
   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      good_nxt  = good_cnt;
      wait_nxt  = wait_cnt;
      win_nxt   = win_cnt;
      err_nxt   = err_cnt;
      loss_nxt  = loss_cnt;
      if (PASSTHROUGH) begin
         state_nxt = ST_HUNT;
         cand_nxt  = '0;
         good_nxt  = '0;
         wait_nxt  = '0;
         win_nxt   = '0;
         err_nxt   = '0;
      end else if (chk_v) begin
         unique case (state)
            ST_HUNT: begin
               if (good) begin
                  if (good_cnt == 10'(LOCK_CNT - 1)) begin
                     state_nxt = ST_LOCKED;
                     good_nxt  = '0;
                     win_nxt   = '0;
                     err_nxt   = '0;
                  end else begin
                     good_nxt = good_cnt + 10'd1;
                  end
               end else begin
                  good_nxt = '0;
                  cand_nxt = (cand == 7'd66) ? 7'd0 : cand + 7'd1;
                  if (SLIP_WAIT != 0) begin
                     state_nxt = ST_WAIT;
                     wait_nxt  = '0;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'(SLIP_WAIT - 1)) begin
                  state_nxt = ST_HUNT;
                  wait_nxt  = '0;
               end else begin
                  wait_nxt = wait_cnt + 4'd1;
               end
            end
            ST_LOCKED: begin
               if (!good && err_cnt == 10'(ERR_LIMIT - 1)) begin
                  state_nxt = ST_HUNT;
                  good_nxt  = '0;
                  wait_nxt  = '0;
                  win_nxt   = '0;
                  err_nxt   = '0;
                  if (loss_cnt != 16'hFFFF)
                     loss_nxt = loss_cnt + 16'd1;
               end else if (win_cnt == 10'(ERR_WINDOW - 1)) begin
                  win_nxt = '0;
                  err_nxt = '0;
               end else begin
                  win_nxt = win_cnt + 10'd1;
                  err_nxt = err_cnt + {9'd0, ~good};
               end
            end
            default: state_nxt = ST_HUNT;
         endcase
      end
   end

   // Aligned output register; holds across idle cycles
   always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         bus.DATA_OUT       <= '0;
         bus.HEADER_OUT     <= '0;
         bus.DATA_OUT_VALID <= 1'b0;
         bus.HEADER_ERR     <= 1'b0;
      end else begin
         bus.DATA_OUT_VALID <= chk_v && (state == ST_LOCKED);
         if (chk_v) begin
            bus.HEADER_OUT <= aligned[65:64];
            bus.HEADER_ERR <= ~good;
            if (INVERT_EN != 0 && aligned[66])
               bus.DATA_OUT <= ~aligned[63:0];
            else
               bus.DATA_OUT <= aligned[63:0];
         end
      end
   end

endmodule

// File: tb/tb_decode_64b67b_sync.sv
// Directed bench for decode_64b67b_sync.
// Expected payloads are queued as words are driven.
module tb_decode_64b67b_sync;

   typedef struct packed {
      logic [63:0] d;
      logic [1:0]  h;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pt;
   logic        locked;
   logic [6:0]  cand;
   logic [15:0] loss;
   int          errors = 0;
   int          checks = 0;

   logic [66:0] enc [0:511];
   logic [63:0] pay [0:511];
   logic [1:0]  hd  [0:511];
   exp_t        q [$];
   exp_t        mon_e;

   decode_64b67b_sync_if bus ();

   decode_64b67b_sync #(
      .LOCK_CNT   (64),
      .ERR_LIMIT  (16),
      .ERR_WINDOW (64),
      .SLIP_WAIT  (2),
      .INVERT_EN  (1)
   ) dut (
      .USER_CLK      (clk),
      .SYSTEM_RESET  (rst),
      .PASSTHROUGH   (pt),
      .bus           (bus),
      .LOCKED        (locked),
      .CANDIDATE     (cand),
      .LOCK_LOSS_CNT (loss)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: random payload; mode 1: bits 28..63 track header bit 0
   task automatic gen(input int n, input int mode);
      logic        inv;
      logic [63:0] lo;
      for (int k = 0; k < n; k++) begin
         hd[k] = k[0] ? 2'b10 : 2'b01;
         inv   = 1'($urandom_range(0, 1));
         if (mode == 0) begin
            pay[k] = {$urandom, $urandom};
            lo     = inv ? ~pay[k] : pay[k];
         end else begin
            lo     = {{36{hd[k][0]}}, 28'($urandom)};
            pay[k] = inv ? ~lo : lo;
         end
         enc[k] = {inv, hd[k], lo};
      end
   endtask

   task automatic set_bad(input int k);
      hd[k] = k[0] ? 2'b11 : 2'b00;
      enc[k][65:64] = hd[k];
   endtask

   task automatic push(input int k);
      exp_t x;
      x.d = pay[k];
      x.h = hd[k];
      x.e = (hd[k] == 2'b00) || (hd[k] == 2'b11);
      q.push_back(x);
   endtask

   function automatic logic [66:0] shifted(input int j);
      logic [133:0] two;
      two = {enc[j+1], enc[j]};
      return 67'(two >> 30);
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_data"}, bus.DATA_OUT, 64'd0);
      chk({tag, "_hdr"},  64'(bus.HEADER_OUT), 64'd0);
      chk({tag, "_vld"},  64'(bus.DATA_OUT_VALID), 64'd0);
      chk({tag, "_herr"}, 64'(bus.HEADER_ERR), 64'd0);
      chk({tag, "_lock"}, 64'(locked), 64'd0);
      chk({tag, "_cand"}, 64'(cand), 64'd0);
      chk({tag, "_loss"}, 64'(loss), 64'd0);
   endtask

   // Scoreboard: every valid output must match the next queued word
   always @(negedge clk) begin
      if (!rst && bus.DATA_OUT_VALID) begin
         chk("out_expected", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("out_data", bus.DATA_OUT, mon_e.d);
            chk("out_hdr",  64'(bus.HEADER_OUT), 64'(mon_e.h));
            chk("out_herr", 64'(bus.HEADER_ERR), 64'(mon_e.e));
         end
      end
   end

   initial begin
      int  w;
      bit  seen;
      int  nafter;

      rst = 1'b1;
      pt  = 1'b0;
      bus.DATA_IN       = '0;
      bus.DATA_IN_VALID = 1'b0;
      #12;
      chk_zero("reset");
      rst = 1'b0;

      // Offset-0 stream: lock, error windows, unlock, passthrough, relock
      gen(440, 0);
      for (int k = 70;  k <= 84;  k++) set_bad(k);
      for (int k = 177; k <= 206; k++) set_bad(k);
      for (int k = 260; k <= 275; k++) set_bad(k);
      for (int j = 0; j <= 430; j++) begin
         bus.DATA_IN       = enc[j];
         bus.DATA_IN_VALID = 1'b1;
         pt = (j < 2) || (j == 350);
         if ((j - 1 >= 64 && j - 1 <= 275) ||
             (j - 1 >= 340 && j - 1 <= 348) ||
             (j - 1 >= 413))
            push(j - 1);
         tick();
         if (j == 64)  chk("lock_before", 64'(locked), 64'd0);
         if (j == 65)  chk("lock_rise", 64'(locked), 64'd1);
         if (j == 131) chk("lock_win_a", 64'(locked), 64'd1);
         if (j == 210) chk("lock_win_bc", 64'(locked), 64'd1);
         if (j == 276) begin
            chk("lock_pre_drop", 64'(locked), 64'd1);
            chk("loss_pre_drop", 64'(loss), 64'd0);
         end
         if (j == 277) begin
            chk("lock_drop", 64'(locked), 64'd0);
            chk("loss_one", 64'(loss), 64'd1);
            chk("cand_kept", 64'(cand), 64'd0);
         end
         if (j == 340) chk("relock_before", 64'(locked), 64'd0);
         if (j == 341) chk("relock_rise", 64'(locked), 64'd1);
         if (j == 350) begin
            chk("pt_lock", 64'(locked), 64'd0);
            chk("pt_cand", 64'(cand), 64'd0);
            chk("pt_loss", 64'(loss), 64'd1);
         end
         if (j == 413) chk("pt_relock_before", 64'(locked), 64'd0);
         if (j == 414) chk("pt_relock_rise", 64'(locked), 64'd1);
      end
      pt = 1'b0;
      bus.DATA_IN_VALID = 1'b0;
      repeat (3) tick();
      chk("b_cand", 64'(cand), 64'd0);
      chk("b_drain", 64'(q.size()), 64'd0);

      // Valid toggling 1,0,1,0
      rst = 1'b1;
      #2;
      rst = 1'b0;
      gen(100, 0);
      w = 0;
      for (int c = 0; c < 170; c++) begin
         bus.DATA_IN_VALID = (c % 2 == 0);
         pt = (c < 2);
         if (c % 2 == 0) begin
            bus.DATA_IN = enc[w];
            if (w - 1 >= 64) push(w - 1);
            w++;
         end
         tick();
         if (c % 2 == 0 && c >= 2)
            chk("idle_no_valid", 64'(bus.DATA_OUT_VALID), 64'd0);
         if (c == 128) chk("tog_lock_before", 64'(locked), 64'd0);
         if (c == 129) chk("tog_lock_rise", 64'(locked), 64'd1);
      end
      pt = 1'b0;
      bus.DATA_IN_VALID = 1'b0;
      #6;
      chk("f_drain", 64'(q.size()), 64'd0);
      chk("f_locked", 64'(locked), 64'd1);

      // Asynchronous reset mid-cycle while locked
      rst = 1'b1;
      #1;
      chk_zero("areset");
      q.delete();
      #4;
      rst = 1'b0;

      // Stream shifted by 37 bits
      gen(260, 1);
      seen   = 1'b0;
      nafter = 0;
      for (int j = 0; j < 230 && nafter < 20; j++) begin
         bus.DATA_IN       = shifted(j);
         bus.DATA_IN_VALID = 1'b1;
         tick();
         if (locked && !seen) begin
            seen = 1'b1;
            chk("c37_cand", 64'(cand), 64'd37);
            chk("c37_within_bound", 64'(j <= 37 * 3 + 64 + 2), 64'd1);
         end
         if (seen) begin
            push(j);
            nafter++;
         end
      end
      chk("c37_lock_seen", 64'(seen), 64'd1);
      bus.DATA_IN_VALID = 1'b0;
      repeat (3) tick();
      chk("c37_locked_end", 64'(locked), 64'd1);
      chk("c37_cand_end", 64'(cand), 64'd37);
      chk("c37_drain", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_64b67b_sync.md
# decode_64b67b_sync

Parametrised 64B/67B block-sync decoder for one Interlaken lane, between lane deserialiser/gearbox and descrambler/framing logic. Accepts unaligned 67-bit words, searches all 67 bit offsets for the alternating sync header, declares and drops lock with programmable thresholds, and outputs aligned, de-inverted 64-bit payloads with headers. Over the first-generation decoder it adds:
- configurable lock/unlock thresholds and a true error window;
- a post-slip hold-off;
- a per-word header-error flag;
- lock-loss statistics.

## Interface
Parameters:
- LOCK_CNT, 64: consecutive good headers needed to lock (1..1024).
- ERR_LIMIT, 16: bad headers within one window that drop lock (1..ERR_WINDOW).
- ERR_WINDOW, 64: checked words per error-counting window while locked (2..1024).
- SLIP_WAIT, 2: checked words ignored after each slip (0..15).
- INVERT_EN, 1: 1 = bit 66 inverts payload; 0 = payload passed unmodified.

Ports:
- USER_CLK  in  1  clock.
- SYSTEM_RESET  in  1  reset; asynchronous and active-high.
- PASSTHROUGH  in  1  synchronous; while high, the sync FSM is held in its reset state and the datapath keeps running.
- DATA_IN  in  67  unaligned word; [66] is newest-order MSB.
- DATA_IN_VALID  in  1  DATA_IN qualifier.
- DATA_OUT  out  64  aligned payload, de-inverted when INVERT_EN.
- HEADER_OUT  out  2  aligned bits [65:64].
- DATA_OUT_VALID  out  1  output qualifier; only while locked.
- HEADER_ERR  out  1  with DATA_OUT_VALID: header was 00 or 11.
- LOCKED  out  1  FSM in LOCKED.
- CANDIDATE  out  7  current bit offset 0..66.
- LOCK_LOSS_CNT  out  16  saturating count of LOCKED->HUNT transitions.

## Operation
- Input stage: on each DATA_IN_VALID edge, capture prev <= DATA_IN and window <= {DATA_IN, prev} (134 bits). Set chk_v <= DATA_IN_VALID every edge.
- aligned = window >> CANDIDATE (low 67 bits, combinational). good = aligned[65] != aligned[64].
- Header checks happen only on cycles with chk_v = 1 (a "checked word").
- FSM states: HUNT, WAIT, LOCKED. Reset state is HUNT.
- HUNT:
  - good: good_cnt++.
  - At good_cnt == LOCK_CNT-1 with good: go to LOCKED and clear both counters.
  - bad: good_cnt = 0; CANDIDATE = (CANDIDATE == 66) ? 0 : CANDIDATE+1; go to WAIT with wait_cnt = 0.
  - If SLIP_WAIT == 0, a bad word slips and stays in HUNT instead of entering WAIT.
- WAIT: ignore header quality. wait_cnt++ per checked word; at wait_cnt == SLIP_WAIT-1, go to HUNT.
- LOCKED: win_cnt++ and err_cnt += bad on every checked word.
  - If bad and err_cnt == ERR_LIMIT-1: go to HUNT, clear all counters, LOCK_LOSS_CNT += 1 (saturates at 0xFFFF). CANDIDATE is unchanged; the next bad word in HUNT slips.
  - Otherwise, at win_cnt == ERR_WINDOW-1: clear win_cnt and err_cnt. The unlock check takes priority over the window end.
  - Good headers never clear err_cnt mid-window.
- Output stage, registered on every chk_v cycle:
  - HEADER_OUT = aligned[65:64].
  - DATA_OUT = (INVERT_EN && aligned[66]) ? ~aligned[63:0] : aligned[63:0].
  - HEADER_ERR = !good.
  - DATA_OUT_VALID = chk_v && (state == LOCKED before that edge's transition).
  - With chk_v = 0, data and header registers hold and DATA_OUT_VALID = 0.
- PASSTHROUGH high: state = HUNT, CANDIDATE = 0, all FSM counters 0. LOCK_LOSS_CNT holds. The input stage still runs.

## Timing
- Reset values: DATA_OUT 0, HEADER_OUT 0, DATA_OUT_VALID 0, HEADER_ERR 0, LOCKED 0, CANDIDATE 0, LOCK_LOSS_CNT 0. prev, window and chk_v also clear to 0.
- Latency: a word accepted at edge k is the newest word of the window after k. Its aligned output appears after edge k+1, so DATA_OUT_VALID is high in cycle k+1..k+2.
- Throughput: one word per cycle. Gaps in DATA_IN_VALID propagate as gaps in DATA_OUT_VALID. Counters advance only on checked words.
- LOCKED rises the cycle after the LOCK_CNT-th consecutive good checked word. The first valid output is the word checked on the following chk_v cycle.
- A slip takes effect combinationally on the next checked word. No word is dropped or duplicated by a slip.
- An async reset asserted mid-lock clears everything at once. After deassertion the FSM starts in HUNT with the window holding zeros. The first checked word after reset compares stale zero bits and is bad, so it slips.

## Test plan
- Aligned stream, offset 0, alternating header 01/10, 100 words contiguous:
  - LOCKED rises after word 64 and CANDIDATE stays 0;
  - the following words appear on DATA_OUT with 2-cycle latency;
  - the payload is inverted when [66] = 1.
- Stream shifted by 37 bits:
  - CANDIDATE walks and settles at 37;
  - LOCKED is reached within 37*(SLIP_WAIT+1)+LOCK_CNT+2 checked words;
  - DATA_OUT matches the original payloads.
- While locked, inject 15 bad headers in one 64-word window:
  - lock is held and HEADER_ERR pulses on exactly those 15 outputs.
  - Then 16 bad headers in one window: LOCKED falls after the 16th and LOCK_LOSS_CNT = 1.
- 15 bad headers at the end of window A and 15 at the start of window B: lock is retained, confirming the window reset.
- DATA_IN_VALID toggling 1,0,1,0: lock takes 64 valid words (about 128 cycles) and DATA_OUT_VALID never asserts on idle cycles.
- While locked, PASSTHROUGH pulses for 1 cycle: LOCKED = 0 and CANDIDATE = 0 next cycle, LOCK_LOSS_CNT is unchanged, and relock completes.
- Async SYSTEM_RESET mid-word: all outputs go to zero immediately, without waiting for a clock edge.
